// File: rtl/clk_ctl_pkg.sv
// clk_ctl_pkg: shared state encoding, default widths and helpers for the clock step controller
package clk_ctl_pkg;
  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    HALT  = 3'd1,
    STEP  = 3'd2,
    BURST = 3'd3,
    RUN   = 3'd4
  } ctl_state_t;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int BURST_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic logic is_busy(ctl_state_t s);
    return s inside {STEP, BURST, RUN};
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous button followed by a one-cycle rising-edge pulse
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic last;
  // shift the raw input through the synchroniser and remember the previous synchronised level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= STAGES'({sync, din});
      last <= sync[STAGES-1];
    end
  end
  assign pulse = sync[STAGES-1] & ~last;
endmodule

// File: rtl/clock_step_controller.sv
// clock_step_controller: sequences the registered active-low CPU clock enable through hold, halt, step, burst and run
module clock_step_controller
  import clk_ctl_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               CP,
  input  logic               _reset,
  input  logic               run_req,
  input  logic               step_btn,
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_req,
  output logic               _clk_en,
  output logic [2:0]         state,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_count
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  ctl_state_t cur, nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_nxt;
  logic step_ev;
  sync_edge #(.STAGES(SYNC_STAGES)) u_step (
    .clk(CP),
    .rst_n(_reset),
    .din(step_btn),
    .pulse(step_ev)
  );
  // next state: halt beats step beats burst beats run; requests outside HALT are dropped
  always_comb begin
    nxt = cur;
    hold_nxt = hold_cnt;
    burst_nxt = burst_cnt;
    case (cur)
      HOLD: begin
        hold_nxt = hold_cnt + 1'b1;
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          nxt = HALT;
          hold_nxt = '0;
        end
      end
      HALT: begin
        if (halt_req) nxt = HALT;
        else if (step_ev) nxt = STEP;
        else if (burst_req && burst_len != '0) begin
          nxt = BURST;
          burst_nxt = burst_len;
        end else if (run_req) nxt = RUN;
      end
      STEP: nxt = HALT;
      BURST: begin
        burst_nxt = burst_cnt - 1'b1;
        if (halt_req || burst_cnt == BURST_W'(1)) begin
          nxt = HALT;
          burst_nxt = '0;
        end
      end
      RUN: nxt = (halt_req || !run_req) ? HALT : RUN;
      default: nxt = HALT;
    endcase
  end
  // register state with its Moore outputs so the enable only moves on the clock edge
  always_ff @(posedge CP) begin
    if (!_reset) begin
      cur <= HOLD;
      hold_cnt <= '0;
      burst_cnt <= '0;
      _clk_en <= 1'b1;
      busy <= 1'b0;
      cycle_count <= '0;
    end else begin
      cur <= nxt;
      hold_cnt <= hold_nxt;
      burst_cnt <= burst_nxt;
      _clk_en <= ~is_busy(nxt);
      busy <= is_busy(nxt);
      if (!_clk_en) cycle_count <= cycle_count + 1'b1;
    end
  end
  assign state = cur;
endmodule

// File: tb/tb_clock_step_controller.sv
// tb_clock_step_controller: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_clock_step_controller;
  logic CP = 1'b0;
  logic _reset = 1'b0, run_req = 1'b0, step_btn = 1'b0, burst_req = 1'b0, halt_req = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic _clk_en, busy, _clk_en4, busy4;
  logic [2:0] state, state4;
  logic [15:0] cycle_count;
  logic [3:0] cycle_count4;
  int total = 0, bad = 0;
  int m_mode = 0, m_hold = 4, m_burst = 0, m_cnt = 0;
  logic [2:0] hist = 3'b000;

  always #5 CP = ~CP;

  clock_step_controller dut (
    .CP(CP), ._reset(_reset), .run_req(run_req), .step_btn(step_btn), .burst_req(burst_req),
    .burst_len(burst_len), .halt_req(halt_req), ._clk_en(_clk_en), .state(state), .busy(busy),
    .cycle_count(cycle_count)
  );
  clock_step_controller #(.CNT_W(4)) dut4 (
    .CP(CP), ._reset(_reset), .run_req(run_req), .step_btn(step_btn), .burst_req(burst_req),
    .burst_len(burst_len), .halt_req(halt_req), ._clk_en(_clk_en4), .state(state4), .busy(busy4),
    .cycle_count(cycle_count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural model: modes 0 hold,1 halt,2 step,3 burst,4 run; step events from button history
  task automatic model_step();
    logic ev;
    logic en_was;
    ev = hist[1] & ~hist[2];
    en_was = m_mode >= 2;
    if (!_reset) begin
      m_mode = 0; m_hold = 4; m_burst = 0; m_cnt = 0; hist = 3'b000;
    end else begin
      if (en_was) m_cnt++;
      hist = {hist[1:0], step_btn};
      if (m_mode == 0) begin
        m_hold--;
        if (m_hold == 0) m_mode = 1;
      end else if (m_mode == 1) begin
        if (halt_req) m_mode = 1;
        else if (ev) m_mode = 2;
        else if (burst_req && burst_len != 0) begin m_mode = 3; m_burst = burst_len; end
        else if (run_req) m_mode = 4;
      end else if (m_mode == 2) m_mode = 1;
      else if (m_mode == 3) begin
        m_burst--;
        if (halt_req || m_burst == 0) m_mode = 1;
      end else if (halt_req || !run_req) m_mode = 1;
    end
  endtask

  task automatic tick();
    logic b;
    @(posedge CP);
    model_step();
    #1;
    b = m_mode >= 2;
    check("tick", {3'd0, state, _clk_en, busy, cycle_count, cycle_count4, state4, _clk_en4},
          {3'd0, 3'(m_mode), ~b, b, 16'(m_cnt), 4'(m_cnt), 3'(m_mode), ~b});
  endtask

  task automatic idle_inputs();
    run_req = 0; step_btn = 0; burst_req = 0; halt_req = 0; burst_len = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    _reset = 0;
    tick();
    _reset = 1;
    repeat (5) tick();
  endtask

  typedef struct {
    logic rst, run, breq, halt;
    logic [7:0] blen;
    logic [2:0] st;
    logic en;
    int cnt;
  } vec_t;
  vec_t tv[18];

  initial begin
    int n_en, first;
    tv[0]  = '{0, 0, 0, 0, 8'd0, 3'd0, 1, 0};
    tv[1]  = '{0, 0, 0, 0, 8'd0, 3'd0, 1, 0};
    tv[2]  = '{0, 0, 0, 0, 8'd0, 3'd0, 1, 0};
    tv[3]  = '{1, 1, 0, 0, 8'd0, 3'd0, 1, 0};
    tv[4]  = '{1, 1, 0, 0, 8'd0, 3'd0, 1, 0};
    tv[5]  = '{1, 1, 0, 0, 8'd0, 3'd0, 1, 0};
    tv[6]  = '{1, 1, 0, 0, 8'd0, 3'd1, 1, 0};
    tv[7]  = '{1, 1, 0, 0, 8'd0, 3'd4, 0, 0};
    tv[8]  = '{1, 1, 0, 0, 8'd0, 3'd4, 0, 1};
    tv[9]  = '{1, 0, 0, 0, 8'd0, 3'd1, 1, 2};
    tv[10] = '{1, 0, 1, 0, 8'd0, 3'd1, 1, 2};
    tv[11] = '{1, 0, 1, 0, 8'd3, 3'd3, 0, 2};
    tv[12] = '{1, 0, 0, 0, 8'd9, 3'd3, 0, 3};
    tv[13] = '{1, 0, 0, 0, 8'd9, 3'd3, 0, 4};
    tv[14] = '{1, 0, 0, 0, 8'd0, 3'd1, 1, 5};
    tv[15] = '{1, 0, 1, 1, 8'd2, 3'd1, 1, 5};
    tv[16] = '{1, 1, 1, 0, 8'd2, 3'd3, 0, 5};
    tv[17] = '{1, 1, 0, 1, 8'd0, 3'd1, 1, 6};
    for (int i = 0; i < 18; i++) begin
      _reset = tv[i].rst; run_req = tv[i].run; burst_req = tv[i].breq;
      halt_req = tv[i].halt; burst_len = tv[i].blen;
      tick();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tv[i].st));
      check($sformatf("vec%0d_clk_en", i), 32'(_clk_en), 32'(tv[i].en));
      check($sformatf("vec%0d_count", i), 32'(cycle_count), tv[i].cnt);
    end

    do_reset();
    step_btn = 1; n_en = 0; first = -1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 11) step_btn = 0;
      tick();
      if (!_clk_en) begin n_en++; if (first < 0) first = i; end
    end
    check("step_en_cycles", n_en, 1);
    check("step_latency", first, 3);
    check("step_count", 32'(cycle_count), 1);

    do_reset();
    burst_req = 1; burst_len = 5; n_en = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      burst_req = 0; burst_len = 8'd77;
      if (!_clk_en) n_en++;
    end
    check("burst5_en_cycles", n_en, 5);
    check("burst5_state", 32'(state), 1);
    check("burst5_count", 32'(cycle_count), 5);
    burst_req = 1; burst_len = 0; n_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      burst_req = 0;
      if (!_clk_en) n_en++;
    end
    check("burst0_en_cycles", n_en, 0);
    check("burst0_count", 32'(cycle_count), 5);

    do_reset();
    burst_len = 200; burst_req = 1;
    tick();
    burst_req = 0;
    tick();
    tick();
    check("abort_pre_state", 32'(state), 3);
    halt_req = 1;
    tick();
    halt_req = 0;
    check("abort_clk_en", 32'(_clk_en), 1);
    check("abort_state", 32'(state), 1);
    check("abort_count", 32'(cycle_count), 3);

    do_reset();
    step_btn = 1;
    tick();
    step_btn = 0;
    tick();
    halt_req = 1; burst_req = 1; burst_len = 4;
    tick();
    check("simul_halt_state", 32'(state), 1);
    check("simul_halt_clk_en", 32'(_clk_en), 1);
    halt_req = 0; burst_req = 0; step_btn = 1;
    tick();
    step_btn = 0;
    tick();
    burst_req = 1; burst_len = 4;
    tick();
    burst_req = 0;
    check("simul_step_state", 32'(state), 2);
    n_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!_clk_en) n_en++;
    end
    check("simul_burst_dropped", n_en, 0);
    check("simul_count", 32'(cycle_count), 1);

    do_reset();
    run_req = 1;
    repeat (5) tick();
    check("midrun_state", 32'(state), 4);
    _reset = 0;
    tick();
    _reset = 1; run_req = 0;
    check("midrun_reset_state", 32'(state), 0);
    check("midrun_reset_clk_en", 32'(_clk_en), 1);
    check("midrun_reset_count", 32'(cycle_count), 0);

    do_reset();
    burst_req = 1; burst_len = 17;
    tick();
    burst_req = 0;
    repeat (20) tick();
    check("wrap_count4", 32'(cycle_count4), 1);
    check("wrap_count16", 32'(cycle_count), 17);
    check("wrap_state", 32'(state), 1);

    for (int i = 0; i < 3000; i++) begin
      _reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) run_req = ~run_req;
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
      burst_req = ($urandom_range(0, 9) == 0);
      burst_len = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      halt_req = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_step_controller.md
Name: clock_step_controller

Overview:
- Sequences the CPU clock enable so the machine can run free, halt, single-step or run a fixed-length burst.
- Sits between the front-panel and CPU halt sources and the clock gate that forms the gated CPU clock from CP.
- Produces one registered active-low enable, _clk_en. It changes only on posedge CP, so the downstream gate never sees a mid-phase transition.

Parameters:
- HOLD_CYCLES, 4: cycles _clk_en stays high (disabled) after reset release.
- BURST_W, 8: width of burst_len.
- CNT_W, 16: width of cycle_count.
- SYNC_STAGES, 2: synchroniser depth for the asynchronous step button.

Ports:
- CP  in  1  system clock; all state updates on posedge.
- _reset  in  1  synchronous active-low reset, sampled on posedge CP.
- run_req  in  1  level; 1 = free-run requested (panel switch, already synchronous).
- step_btn  in  1  asynchronous raw step button, active-high.
- burst_req  in  1  single-cycle pulse; starts a burst of burst_len enabled cycles.
- burst_len  in  BURST_W  burst length, captured when burst_req is accepted.
- halt_req  in  1  single-cycle pulse from the CPU HALT decode.
- _clk_en  out  1  active-low CPU clock enable, registered.
- state  out  3  current FSM state encoding.
- busy  out  1  1 in STEP, BURST or RUN.
- cycle_count  out  CNT_W  number of enabled cycles since reset, wraps.

Behaviour:
- Reset (_reset=0 at posedge):
  - state=HOLD, _clk_en=1, busy=0, cycle_count=0.
  - Hold counter=0, burst counter=0, synchroniser and edge register cleared.
  - Reset wins over every other input, including mid-burst or mid-run.
- States and transitions (evaluated each posedge; one transition per cycle):
  - HOLD: count HOLD_CYCLES cycles, then go to HALT. No request is honoured in HOLD, and requests arriving in HOLD are dropped.
  - HALT:
    - halt_req: stay in HALT.
    - else step edge: go to STEP.
    - else burst_req with burst_len!=0: go to BURST, load counter=burst_len.
    - else run_req=1: go to RUN.
    - burst_req with burst_len=0 is ignored.
  - STEP: exactly one cycle with _clk_en=0, then back to HALT.
  - BURST: _clk_en=0 each cycle, counter decrements. Counter reaching 1 means the last enabled cycle; the next state is HALT. halt_req aborts to HALT immediately, so no enabled cycle follows the halt_req cycle.
  - RUN: _clk_en=0 while in RUN. Exits to HALT on halt_req or on run_req=0.
- Output timing:
  - _clk_en is a registered Moore output: _clk_en=0 exactly in cycles where registered state is STEP, BURST or RUN; otherwise 1.
  - Latency from an accepted request to _clk_en falling: 1 posedge.
  - Latency from halt_req to _clk_en rising: 1 posedge.
- Priority on simultaneous events: _reset > halt_req > step > burst > run.
  - halt_req has no effect in HALT or HOLD beyond blocking other requests that cycle.
  - step and burst_req arriving while busy are dropped; they are not queued.
- Step synchroniser:
  - SYNC_STAGES flops, then rising-edge detect gives exactly one step event per button press.
  - Button held high yields no further events.
  - Step latency from button edge to STEP: SYNC_STAGES+1 cycles.
- cycle_count:
  - Increments by 1 on every posedge where registered _clk_en=0.
  - Wraps 2^CNT_W-1 to 0 with no flag.
- busy = state in {STEP, BURST, RUN}, registered with state.
- burst_len is sampled only at acceptance; later changes do not affect a burst in progress.

Decomposition:
- Package clk_ctl_pkg holds:
  - enum ctl_state_t (3 bits): HOLD=0, HALT=1, STEP=2, BURST=3, RUN=4.
  - Default width constants.
- One sub-module: sync_edge, a SYNC_STAGES-deep synchroniser plus rising-edge pulse with synchronous active-low reset. It is reused for other panel buttons.

Test Plan:
- Reset hold: assert _reset=0 for 3 cycles, then release with run_req=1.
  - Required: _clk_en=1 for exactly 4 cycles, 1 cycle in HALT, then _clk_en=0 from the following posedge.
- Single step: from HALT, pulse step_btn high for 10 cycles.
  - Required: exactly one cycle of _clk_en=0, occurring 3 posedges after the button edge; cycle_count increments 0→1.
- Burst: burst_req with burst_len=5.
  - Required: exactly 5 consecutive _clk_en=0 cycles, then HALT; cycle_count +5.
  - Repeat with burst_len=0: no enabled cycles.
- Halt abort: burst_len=200; assert halt_req in the 3rd enabled cycle.
  - Required: _clk_en=1 at the next posedge, state=HALT, cycle_count=3.
- Simultaneous events: in HALT, assert halt_req, step edge and burst_req in the same cycle → stays HALT. Next cycle, step edge plus burst_req → STEP only, burst dropped.
- Reset mid-run and wrap:
  - In RUN, drive _reset=0 for one cycle → HOLD, _clk_en=1, cycle_count=0.
  - Separately, with CNT_W=4, run 17 enabled cycles → cycle_count=1.
